// File: rtl/keypad_if.sv
// Keypad pin/command bundle between the scan controller and its surroundings.
// The controller drives rows and key reports and senses the columns.
interface keypad_if;
  logic [3:0] col_in;
  logic [3:0] row_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  modport master (
    input  col_in,
    output row_out,
    output key_code,
    output key_valid,
    output key_held
  );

  modport slave (
    output col_in,
    input  row_out,
    input  key_code,
    input  key_valid,
    input  key_held
  );
endinterface

// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner: rotates a one-hot row drive, samples columns at the
// end of each row slot, and debounces press/release with one shared timer.
module keypad_scan_ctrl #(
  parameter int unsigned SCAN_DIV = 1000,
  parameter int unsigned DEBOUNCE = 200000
) (
  input  logic     clk,
  input  logic     reset,
  keypad_if.master kp
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned TMR_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(DEBOUNCE - 1);

  typedef enum logic [1:0] {
    SCAN,
    WAIT_PRESS,
    HELD,
    WAIT_RELEASE
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic [TMR_W-1:0] timer;
  logic [1:0]       row_idx;
  logic [1:0]       col_idx;
  logic [3:0]       row_q;
  logic [3:0]       code_q;
  logic             valid_q;
  logic             held_q;

  logic [1:0]       low_col;
  logic             col_bit;

  // Lowest-indexed set column wins when several keys in a row are down.
  always_comb begin
    low_col = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (kp.col_in[i]) low_col = 2'(i);
    end
  end

  assign col_bit = kp.col_in[col_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= SCAN;
      div_cnt <= '0;
      timer   <= '0;
      row_idx <= 2'd0;
      col_idx <= 2'd0;
      row_q   <= 4'b0001;
      code_q  <= 4'd0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state)
        SCAN: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (kp.col_in != 4'd0) begin
              col_idx <= low_col;
              timer   <= '0;
              state   <= WAIT_PRESS;
            end else begin
              row_q   <= {row_q[2:0], row_q[3]};
              row_idx <= row_idx + 2'd1;
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        WAIT_PRESS: begin
          if (!col_bit) begin
            state   <= SCAN;
            div_cnt <= '0;
            row_q   <= {row_q[2:0], row_q[3]};
            row_idx <= row_idx + 2'd1;
          end else if (timer == TMR_LAST) begin
            state   <= HELD;
            code_q  <= {row_idx, col_idx};
            valid_q <= 1'b1;
            held_q  <= 1'b1;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end

        HELD: begin
          if (!col_bit) begin
            timer <= '0;
            state <= WAIT_RELEASE;
          end
        end

        WAIT_RELEASE: begin
          // A reassertion before the timer expires is treated as release bounce.
          if (col_bit) begin
            state <= HELD;
          end else if (timer == TMR_LAST) begin
            state   <= SCAN;
            div_cnt <= '0;
            held_q  <= 1'b0;
            row_q   <= {row_q[2:0], row_q[3]};
            row_idx <= row_idx + 2'd1;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end

        default: state <= SCAN;
      endcase
    end
  end

  assign kp.row_out   = row_q;
  assign kp.key_code  = code_q;
  assign kp.key_valid = valid_q;
  assign kp.key_held  = held_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with SCAN_DIV=4, DEBOUNCE=8: a run-length
// reference model is checked every cycle, plus literal expectations per scenario.
module tb_keypad_scan_ctrl;

  localparam int SD = 4;
  localparam int DB = 8;

  logic clk;
  logic reset;
  keypad_if kif ();

  keypad_scan_ctrl #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
    .clk   (clk),
    .reset (reset),
    .kp    (kif.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_err = 0;

  // Reference model: row slot position, qualifying run lengths, reported key.
  int         m_row, m_pos, m_phase, m_run, m_col;
  logic [3:0] m_code;
  logic       m_valid, m_held;
  bit         m_ok = 0;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_row();
    m_phase = 0;
    m_pos   = 0;
    m_row   = (m_row + 1) % 4;
  endtask

  // Phases: 0 scanning, 1 press qualifying, 2 key down, 3 release qualifying.
  task automatic model_step(input logic r, input logic [3:0] c);
    if (r) begin
      m_row = 0; m_pos = 0; m_phase = 0; m_run = 0; m_col = 0;
      m_code = 4'd0; m_valid = 1'b0; m_held = 1'b0; m_ok = 1;
      return;
    end
    m_valid = 1'b0;
    case (m_phase)
      0: begin
        if (m_pos == SD - 1) begin
          if (c != 4'd0) begin
            for (int i = 3; i >= 0; i--) if (c[i]) m_col = i;
            m_run = 0; m_phase = 1; m_pos = 0;
          end else next_row();
        end else m_pos++;
      end
      1: begin
        if (!c[m_col]) next_row();
        else begin
          m_run++;
          if (m_run == DB) begin
            m_phase = 2; m_code = 4'(m_row * 4 + m_col);
            m_valid = 1'b1; m_held = 1'b1;
          end
        end
      end
      2: if (!c[m_col]) begin m_phase = 3; m_run = 0; end
      default: begin
        if (c[m_col]) m_phase = 2;
        else begin
          m_run++;
          if (m_run == DB) begin m_held = 1'b0; next_row(); end
        end
      end
    endcase
  endtask

  // One clock: check current DUT outputs against the model, then apply inputs.
  task automatic tick(input logic r, input logic [3:0] c);
    @(negedge clk);
    if (m_ok) begin
      check("row_out",   kif.row_out,         4'(1 << m_row));
      check("key_code",  kif.key_code,        m_code);
      check("key_valid", {3'd0, kif.key_valid}, {3'd0, m_valid});
      check("key_held",  {3'd0, kif.key_held},  {3'd0, m_held});
    end
    model_step(r, c);
    reset      = r;
    kif.col_in = c;
  endtask

  // Idle until the next clock is the column sample for row r.
  task automatic scan_to(input int r);
    int guard;
    guard = 0;
    while (!(m_phase == 0 && m_row == r && m_pos == SD - 1) && guard < 64) begin
      tick(1'b0, 4'd0);
      guard++;
    end
    check("scan_to_timeout", 4'(guard == 64), 4'd0);
  endtask

  initial begin
    reset      = 1'b1;
    kif.col_in = 4'd0;

    tick(1'b1, 4'd0);
    tick(1'b1, 4'd0);

    // Idle scan: four cycles per row, wrapping back to row 0 at cycle 16.
    for (int j = 0; j <= 16; j++) begin
      tick(1'b0, 4'd0);
      check("idle_row", kif.row_out, 4'(1 << ((j / 4) % 4)));
      check("idle_valid", {3'd0, kif.key_valid}, 4'd0);
    end

    // Press bounce on row 2: column drops after 3 qualifying cycles.
    scan_to(2);
    tick(1'b0, 4'b0010);
    for (int i = 0; i < 3; i++) tick(1'b0, 4'b0010);
    tick(1'b0, 4'b0000);
    check("bounce_frozen_row", kif.row_out, 4'b0100);
    tick(1'b0, 4'b0000);
    check("bounce_next_row", kif.row_out, 4'b1000);
    check("bounce_held", {3'd0, kif.key_held}, 4'd0);
    check("bounce_valid", {3'd0, kif.key_valid}, 4'd0);

    // Clean press on row 2, column 1: valid on the 9th cycle after the sample.
    scan_to(2);
    tick(1'b0, 4'b0010);
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 4'b0010);
      check("press_wait_valid", {3'd0, kif.key_valid}, 4'd0);
      check("press_wait_row", kif.row_out, 4'b0100);
    end
    tick(1'b0, 4'b0010);
    check("press_valid", {3'd0, kif.key_valid}, 4'd1);
    check("press_code", kif.key_code, 4'd9);
    check("press_held", {3'd0, kif.key_held}, 4'd1);
    tick(1'b0, 4'b0010);
    check("press_valid_once", {3'd0, kif.key_valid}, 4'd0);

    // Release bounce: three low cycles then back high keeps the key down.
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 4'b0000);
      check("rel_bounce_held", {3'd0, kif.key_held}, 4'd1);
    end
    tick(1'b0, 4'b0010);
    tick(1'b0, 4'b0010);
    check("rel_bounce_novalid", {3'd0, kif.key_valid}, 4'd0);
    check("rel_bounce_held2", {3'd0, kif.key_held}, 4'd1);

    // Full release: HELD cycle plus 8 qualifying cycles, then scanning row 3.
    for (int i = 0; i < 9; i++) begin
      tick(1'b0, 4'b0000);
      check("release_wait_held", {3'd0, kif.key_held}, 4'd1);
    end
    tick(1'b0, 4'b0000);
    check("release_held", {3'd0, kif.key_held}, 4'd0);
    check("release_row", kif.row_out, 4'b1000);
    check("release_code", kif.key_code, 4'd9);

    // Two keys on row 0: lowest column reported, column 3 toggling ignored.
    scan_to(0);
    tick(1'b0, 4'b1010);
    for (int i = 0; i < 8; i++) tick(1'b0, 4'b1010);
    tick(1'b0, 4'b0010);
    check("multi_valid", {3'd0, kif.key_valid}, 4'd1);
    check("multi_code", kif.key_code, 4'd1);
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, (i % 2 == 0) ? 4'b1010 : 4'b0010);
      check("multi_held", {3'd0, kif.key_held}, 4'd1);
      check("multi_novalid", {3'd0, kif.key_valid}, 4'd0);
      check("multi_code_hold", kif.key_code, 4'd1);
    end
    for (int i = 0; i < 10; i++) tick(1'b0, 4'b0000);

    // Reset while press qualifying at timer 5 on row 1.
    scan_to(1);
    tick(1'b0, 4'b0100);
    for (int i = 0; i < 5; i++) tick(1'b0, 4'b0100);
    tick(1'b1, 4'b0100);
    tick(1'b0, 4'b0000);
    check("rst_row", kif.row_out, 4'b0001);
    check("rst_held", {3'd0, kif.key_held}, 4'd0);
    check("rst_code", kif.key_code, 4'd0);
    for (int i = 0; i < 12; i++) begin
      tick(1'b0, 4'b0000);
      check("rst_novalid", {3'd0, kif.key_valid}, 4'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
